hazard_fwd_ctrl: RTL and testbench

- Hazard and forwarding controller for the 3-stage pipeline (IF -> DE -> MW).
- Tracks the instruction currently in MW with its own shadow registers.
- Drives the 1-bit operand-forwarding selects for both DE source muxes (0 = regfile read data, 1 = MW result).
- Stalls IF/DE while an MW load waits on a variable-latency data-memory ack, and flushes IF/DE on a taken branch resolved in DE.

---
 rtl/hazard_fwd_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control for the IF -> DE -> MW pipeline.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_fwd_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_de,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic              rs1_used_de,
  input  logic              rs2_used_de,
  input  logic [REG_AW-1:0] rd_de,
  input  logic              regwrite_de,
  input  logic              memread_de,
  input  logic              branch_taken_de,
  input  logic              dmem_ack,
  output logic              forward_ae,
  output logic              forward_be,
  output logic              stall_if,
  output logic              stall_de,
  output logic              flush_de,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic              err_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              mw_valid_q, mw_valid_d;
  logic [REG_AW-1:0] mw_rd_q, mw_rd_d;
  logic              mw_regwrite_q, mw_regwrite_d;
  logic              mw_load_q, mw_load_d;
  logic              stall;
  logic              fwd_ok;

  assign stall  = mw_valid_q & mw_load_q & ~dmem_ack;
  assign fwd_ok = valid_de & mw_valid_q & mw_regwrite_q
                & (mw_rd_q != '0);

  assign stall_if    = stall;
  assign stall_de    = stall;
  assign forward_ae  = fwd_ok & rs1_used_de & (mw_rd_q == rs1_de);
  assign forward_be  = fwd_ok & rs2_used_de & (mw_rd_q == rs2_de);
  assign flush_de    = valid_de & branch_taken_de & ~stall;
  assign err_timeout = err_q;

  always_comb begin
    mw_valid_d    = mw_valid_q;
    mw_rd_d       = mw_rd_q;
    mw_regwrite_d = mw_regwrite_q;
    mw_load_d     = mw_load_q;
    if (!stall) begin
      mw_valid_d    = valid_de;
      mw_rd_d       = rd_de;
      mw_regwrite_d = regwrite_de;
      mw_load_d     = memread_de;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      RUN: begin
        if (stall) begin
          state_d    = WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CW'(MEM_TIMEOUT)) begin
          err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      err_q         <= 1'b0;
      mw_valid_q    <= 1'b0;
      mw_rd_q       <= '0;
      mw_regwrite_q <= 1'b0;
      mw_load_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      err_q         <= err_d;
      mw_valid_q    <= mw_valid_d;
      mw_rd_q       <= mw_rd_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_load_q     <= mw_load_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_de && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized + directed bench for hazard_fwd_ctrl against a
// cycle-level reference model of the hazard rules.
module tb_hazard_fwd_ctrl;

  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_de;
  logic [AW-1:0] rs1_de, rs2_de, rd_de;
  logic          rs1_used_de, rs2_used_de;
  logic          regwrite_de, memread_de;
  logic          branch_taken_de, dmem_ack;
  logic          forward_ae, forward_be;
  logic          stall_if, stall_de, flush_de;
  logic          err_timeout;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_fwd_ctrl #(
    .REG_AW(AW),
    .MEM_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_de(valid_de),
    .rs1_de(rs1_de),
    .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de),
    .rs2_used_de(rs2_used_de),
    .rd_de(rd_de),
    .regwrite_de(regwrite_de),
    .memread_de(memread_de),
    .branch_taken_de(branch_taken_de),
    .dmem_ack(dmem_ack),
    .forward_ae(forward_ae),
    .forward_be(forward_be),
    .stall_if(stall_if),
    .stall_de(stall_de),
    .flush_de(flush_de),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the instruction sitting in MW plus the
  // length of the current run of consecutive stall cycles.
  logic          m_v, m_rw, m_ld;
  logic [AW-1:0] m_rd;
  int            m_run;
  logic          m_err;
  int            m_sc, m_fc;
  logic          m_stall, m_flush;

  logic obs_fa, obs_fb, obs_stall, obs_flush, obs_err;
  int   obs_sc, obs_fc;

  task automatic check(input string tag,
                       input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s obs=%0d exp=%0d t=%0t",
                  tag, obs, exp, $time);
  endtask

  function automatic logic fwd(input logic [AW-1:0] rs,
                               input logic used);
    return valid_de && used && m_v && m_rw &&
           m_rd != 0 && m_rd == rs;
  endfunction

  task automatic model_clear();
    m_v = 0; m_rw = 0; m_ld = 0; m_rd = '0;
    m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    m_stall = m_v && m_ld && !dmem_ack;
    m_flush = valid_de && branch_taken_de && !m_stall;
    obs_fa = forward_ae;   obs_fb = forward_be;
    obs_stall = stall_if;  obs_flush = flush_de;
    obs_err = err_timeout;
    check("fwd_a", int'(forward_ae), int'(fwd(rs1_de, rs1_used_de)));
    check("fwd_b", int'(forward_be), int'(fwd(rs2_de, rs2_used_de)));
    check("stall_if", int'(stall_if), int'(m_stall));
    check("stall_de", int'(stall_de), int'(m_stall));
    check("flush", int'(flush_de), int'(m_flush));
    check("err", int'(err_timeout), int'(m_err));
`ifdef HAZARD_PERF_EN
    obs_sc = int'(stall_cnt); obs_fc = int'(flush_cnt);
    check("stall_cnt", obs_sc, m_sc);
    check("flush_cnt", obs_fc, m_fc);
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (m_stall) begin
        if (m_run >= TO) m_err = 1;
        m_run++;
        if (m_sc < 65535) m_sc++;
      end else begin
        m_run = 0;
        m_v = valid_de; m_rd = rd_de;
        m_rw = regwrite_de; m_ld = memread_de;
      end
      if (m_flush && m_fc < 65535) m_fc++;
    end
    #1;
  endtask

  task automatic de(input logic v, input int r1, input logic u1,
                    input int r2, input logic u2, input int rd,
                    input logic rw, input logic ld, input logic br);
    valid_de = v;
    rs1_de = AW'(r1); rs1_used_de = u1;
    rs2_de = AW'(r2); rs2_used_de = u2;
    rd_de = AW'(rd); regwrite_de = rw;
    memread_de = ld; branch_taken_de = br;
  endtask

  task automatic idle();
    de(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle(); dmem_ack = 0; rst_n = 0;
    step();
    rst_n = 1;
  endtask

  int nst, nfl, first_err;

  initial begin
    idle(); dmem_ack = 0; rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    model_clear();
    rst_n = 1;

    step();
    check("rst_fwd_a", int'(obs_fa), 0);
    check("rst_stall", int'(obs_stall), 0);
    check("rst_err", int'(obs_err), 0);

    // ALU forward
    de(1, 1, 1, 2, 1, 5, 1, 0, 0); step();
    de(1, 5, 1, 6, 1, 9, 1, 0, 0); step();
    check("alu_fa", int'(obs_fa), 1);
    check("alu_fb", int'(obs_fb), 0);
    check("alu_stall", int'(obs_stall), 0);

    // x0 never forwarded
    de(1, 1, 1, 1, 1, 0, 1, 0, 0); step();
    de(1, 0, 1, 0, 1, 3, 1, 0, 0); step();
    check("x0_fa", int'(obs_fa), 0);
    check("x0_fb", int'(obs_fb), 0);

    // Load wait + branch vs stall, back to back after reset
    do_reset();
    de(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
    de(1, 7, 1, 1, 1, 8, 1, 0, 0);
    nst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nst += int'(obs_stall);
    end
    check("ld_stall_cycles", nst, 3);
    dmem_ack = 1; step();
    check("ld_ack_stall", int'(obs_stall), 0);
    check("ld_ack_fa", int'(obs_fa), 1);
    dmem_ack = 0; idle(); step();
    check("ld_after_stall", int'(obs_stall), 0);

    de(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
    de(1, 2, 1, 3, 1, 0, 0, 0, 1);
    nfl = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      nfl += int'(obs_flush);
    end
    check("br_flush_stalled", nfl, 0);
    dmem_ack = 1; step();
    check("br_flush_ack", int'(obs_flush), 1);
    dmem_ack = 0; idle(); step();
    check("br_flush_after", int'(obs_flush), 0);
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt", obs_sc, 5);
    check("perf_flush_cnt", obs_fc, 1);
`endif

    // Timeout: never acked
    do_reset();
    de(1, 0, 0, 0, 0, 4, 1, 1, 0); step();
    idle();
    first_err = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (obs_err && first_err == 0) first_err = i;
    end
    check("to_first_err", first_err, 6);
    check("to_stall_held", int'(obs_stall), 1);
    do_reset();
    step();
    check("to_rst_err", int'(obs_err), 0);
    check("to_rst_stall", int'(obs_stall), 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int ack_pct;
      ack_pct = (i / 200) % 3 == 2 ? 1 : 6;
      rst_n = ($urandom_range(0, 79) != 0);
      de($urandom_range(0, 3) != 0,
         $urandom_range(0, 3), $urandom_range(0, 1),
         $urandom_range(0, 3), $urandom_range(0, 1),
         $urandom_range(0, 3), $urandom_range(0, 1),
         $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      dmem_ack = ($urandom_range(0, 9) < ack_pct);
      step();
    end
    rst_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
